multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multi-cycle RV32I control FSM that drives the ALU's alu_op/operand selects and consumes alu_bcond for branch resolution; it is the producer end of the ALU control interface.
- Sequences IF/ID/EX/MEM/WB and handshakes with a single shared instruction/data memory port.
- Sits between the instruction register and the datapath muxes, register-file write enable and PC write enable.

Parameters:
- MEM_TIMEOUT, 0, if nonzero: halt with illegal=1 after this many cycles waiting on mem_ready; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- ir  input  32  instruction register contents; valid from the ID state onward
- mem_ready  input  1  memory completes the current request this cycle
- alu_bcond  input  1  ALU compare result
- rf_x17_eq_10  input  1  register x17 equals 10 (ECALL halt condition)
- mem_req  output  1  memory request; held until mem_ready
- mem_we  output  1  store when mem_req=1
- iord  output  1  0 = address from PC, 1 = address from ALUOut
- ir_write  output  1  latch memory data into ir
- aluout_write  output  1  latch ALU result into ALUOut
- alu_src_a  output  1  0 = PC, 1 = register A
- alu_src_b  output  2  0 = register B, 1 = constant 4, 2 = immediate
- alu_op  output  4  ALU operation code
- reg_write  output  1  register-file write enable
- wb_sel  output  2  0 = ALUOut, 1 = MDR, 2 = PC+4
- pc_write  output  1  PC update enable
- pc_source  output  2  0 = PC+4, 1 = ALUOut, 2 = live ALU result
- is_halted  output  1  sticky halt indication
- illegal  output  1  sticky illegal-instruction / timeout flag

Behaviour:
- State register only; every output is combinational from state, ir, mem_ready and alu_bcond.
- While reset_n=0: state=IF and all outputs are forced to 0. The counter and flags clear asynchronously.
- alu_op codes: ADD=0000 (bcond EQ), SUB=0001, AND=0100, OR=0101, XOR=1000 (bcond unsigned LT), NE-compare=1010 (bcond NE), GEU-compare=1011 (bcond unsigned GE). All ALU compares are unsigned.
- IF: mem_req=1, iord=0. Stay in IF until mem_ready. On mem_ready: ir_write=1, next state ID.
- ID: alu_src_a=0, alu_src_b=2, ADD, aluout_write=1 (branch/JAL target). Next state by ir[6:0]:
  - 0110011 or 0010011 -> EX
  - 0000011 or 0100011 -> EX
  - 1100011 -> BR
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 1110011 -> ECALL handling
  - any other opcode -> HALT with illegal=1
- ECALL: if rf_x17_eq_10 -> HALT. Otherwise pc_write=1, pc_source=0, next state IF.
- EX:
  - ALU ops: alu_src_a=1; alu_src_b=0 for R-type, 2 for I-type.
  - funct3 000 -> ADD, or SUB when R-type and ir[30]=1. funct3 100 -> XOR, 110 -> OR, 111 -> AND.
  - Any other funct3 -> HALT with illegal=1.
  - Loads/stores: ADD with immediate.
  - aluout_write=1. Next state MEM for loads/stores, WB otherwise.
- BR: alu_src_a=1, alu_src_b=0.
  - funct3 000 -> 0000, 001 -> 1010, 110 -> 1000, 111 -> 1011. Funct3 100/101 (signed) -> HALT with illegal=1.
  - pc_write=1; pc_source=1 if alu_bcond, else 0. Next state IF.
- MEM: mem_req=1, iord=1, mem_we = store. Wait for mem_ready.
  - Load -> WB.
  - Store -> pc_write=1, pc_source=0, next state IF.
- WB: reg_write=1; wb_sel=1 for a load, 0 otherwise; pc_write=1, pc_source=0. Next state IF.
- JAL: reg_write=1, wb_sel=2, pc_write=1, pc_source=1. Next state IF.
- JALR: alu_src_a=1, alu_src_b=2, ADD, reg_write=1, wb_sel=2, pc_write=1, pc_source=2. Next state IF.
- HALT: is_halted=1 and no other enables. Exit only by reset.
- Memory wait: mem_req stays high and mem_we stays stable until mem_ready; there is no request without the enclosing state. A wait-cycle counter clears on each state entry.
- Reset mid-wait abandons the request immediately (mem_req drops asynchronously).

Decomposition:
- Shared package holds:
  - opcode constants
  - alu_op encodings, shared with the ALU
  - state enumeration (IF, ID, EX, MEM, WB, BR, JAL, JALR, HALT)
  - wb_sel and pc_source codes
- Sub-module alu_op_decode: combinational mapping (state class, funct3, funct7[5]) -> alu_op plus an illegal bit.

Test Plan:
- ir=0x002081B3 (add), mem_ready 2 cycles after request:
  - IF lasts 3 cycles, then ID, EX and WB.
  - EX drives alu_op=0000, src_a=1, src_b=0.
  - WB drives reg_write=1, pc_source=0.
- ir=0x402081B3 (sub) -> EX alu_op=0001. ir=0x0020F1B3 (and) -> alu_op=0100.
- ir=0x00208463 (beq) in BR: alu_op=0000. bcond=1 -> pc_source=1; bcond=0 -> pc_source=0; pc_write=1 in both cases.
- ir=0x0040A183 (lw):
  - MEM holds mem_req=1, iord=1, mem_we=0 for 4 cycles until mem_ready.
  - WB then drives wb_sel=1, reg_write=1.
- ir=0x00000073 (ecall): rf_x17_eq_10=1 -> is_halted=1 sticky; rf_x17_eq_10=0 -> pc_write with PC+4, next state IF.
- reset_n low mid-MEM (sw 0x0020A223): all outputs go to 0 immediately; after release, state is IF with mem_req=1, iord=0.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit and the ALU it drives.
// Holds opcode constants, alu_op encodings, the control state enumeration,
// operand/write-back/PC source codes and the operation class used by alu_op_decode.
package multicycle_control_unit_pkg;

  localparam int unsigned OPC_W    = 7;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned CNT_W    = 32;

  // RV32I major opcodes handled by the control unit
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  // ALU operation codes; the compare result on alu_bcond is unsigned throughout
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD     = 4'b0000,  // bcond: EQ
    ALU_SUB     = 4'b0001,
    ALU_AND     = 4'b0100,
    ALU_OR      = 4'b0101,
    ALU_XOR     = 4'b1000,  // bcond: unsigned LT
    ALU_CMP_NE  = 4'b1010,  // bcond: NE
    ALU_CMP_GEU = 4'b1011   // bcond: unsigned GE
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_BR, S_JAL, S_JALR, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC4    = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_SRC_PC4    = 2'd0,
    PC_SRC_ALUOUT = 2'd1,
    PC_SRC_ALU    = 2'd2
  } pc_src_e;

  localparam logic       SRC_A_PC   = 1'b0;
  localparam logic       SRC_A_REG  = 1'b1;
  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  // What the ALU is being used for in the current state
  typedef enum logic [2:0] {
    CLS_NONE, CLS_ALU_R, CLS_ALU_I, CLS_ADDR, CLS_BRANCH
  } op_class_e;

endpackage

// File: rtl/multicycle_control_unit_alu_op_decode.sv
// Combinational alu_op selection for the control unit.
// Ports: cls_i (operation class), funct3_i, funct7_5_i (ir[30]) ->
//        alu_op_o (ALU operation code), illegal_o (unsupported funct3).
module multicycle_control_unit_alu_op_decode
  import multicycle_control_unit_pkg::*;
(
  input  op_class_e  cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output alu_op_e    alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (cls_i)
      CLS_ALU_R, CLS_ALU_I: begin
        case (funct3_i)
          3'b000: begin
            // ir[30] selects SUB only for register-register ops; for ADDI it is immediate data
            if (cls_i == CLS_ALU_R && funct7_5_i) alu_op_o = ALU_SUB;
            else                                  alu_op_o = ALU_ADD;
          end
          3'b100:  alu_op_o  = ALU_XOR;
          3'b110:  alu_op_o  = ALU_OR;
          3'b111:  alu_op_o  = ALU_AND;
          default: illegal_o = 1'b1;
        endcase
      end
      CLS_BRANCH: begin
        // Signed compares (BLT/BGE) have no ALU support
        case (funct3_i)
          3'b000:  alu_op_o  = ALU_ADD;
          3'b001:  alu_op_o  = ALU_CMP_NE;
          3'b110:  alu_op_o  = ALU_XOR;
          3'b111:  alu_op_o  = ALU_CMP_GEU;
          default: illegal_o = 1'b1;
        endcase
      end
      default: alu_op_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences IF/ID/EX/MEM/WB over a single shared
// memory port and drives the datapath muxes, ALU operation and write enables.
// Ports: clk, reset_n (async active-low); ir, mem_ready, alu_bcond, rf_x17_eq_10 in;
//        mem_req/mem_we/iord, ir_write, aluout_write, alu_src_a/b, alu_op,
//        reg_write, wb_sel, pc_write, pc_source, is_halted, illegal out.
// Outputs are decoded combinationally from the current state and inputs and are
// forced low while reset_n is asserted.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        alu_bcond,
  input  logic        rf_x17_eq_10,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        aluout_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        pc_write,
  output logic [1:0]  pc_source,
  output logic        is_halted,
  output logic        illegal
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [OPC_W-1:0] opcode;
  logic [2:0]       funct3;
  logic             is_r, is_i, is_load, is_store;
  logic             timeout_c;
  op_class_e        cls;
  alu_op_e          dec_alu_op;
  logic             dec_illegal;
  logic             unused_ir_bits;

  assign opcode   = ir[6:0];
  assign funct3   = ir[14:12];
  assign is_r     = (opcode == OPC_OP);
  assign is_i     = (opcode == OPC_OP_IMM);
  assign is_load  = (opcode == OPC_LOAD);
  assign is_store = (opcode == OPC_STORE);

  assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

  // Fires on the last allowed waiting cycle; only meaningful while mem_ready is low
  assign timeout_c = (MEM_TIMEOUT != 0) && (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // ALU usage class for the decoder
  always_comb begin
    cls = CLS_NONE;
    if (state_q == S_EX) begin
      if (is_r)                     cls = CLS_ALU_R;
      else if (is_i)                cls = CLS_ALU_I;
      else if (is_load || is_store) cls = CLS_ADDR;
    end else if (state_q == S_BR) begin
      cls = CLS_BRANCH;
    end
  end

  multicycle_control_unit_alu_op_decode u_alu_op_decode (
    .cls_i      (cls),
    .funct3_i   (funct3),
    .funct7_5_i (ir[30]),
    .alu_op_o   (dec_alu_op),
    .illegal_o  (dec_illegal)
  );

  // State, sticky illegal flag and memory wait counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IF;
      illegal_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    wait_cnt_d   = wait_cnt_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    aluout_write = 1'b0;
    alu_src_a    = SRC_A_PC;
    alu_src_b    = SRC_B_REG;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    wb_sel       = WB_ALUOUT;
    pc_write     = 1'b0;
    pc_source    = PC_SRC_PC4;
    is_halted    = 1'b0;
    illegal      = illegal_q;

    case (state_q)
      S_IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_ID;
        end else if (timeout_c) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end

      S_ID: begin
        // Branch/JAL target PC+imm is captured here while the opcode is decoded
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_IMM;
        alu_op       = ALU_ADD;
        aluout_write = 1'b1;
        case (opcode)
          OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE: state_d = S_EX;
          OPC_BRANCH: state_d = S_BR;
          OPC_JAL:    state_d = S_JAL;
          OPC_JALR:   state_d = S_JALR;
          OPC_SYSTEM: begin
            if (rf_x17_eq_10) begin
              state_d = S_HALT;
            end else begin
              pc_write  = 1'b1;
              pc_source = PC_SRC_PC4;
              state_d   = S_IF;
            end
          end
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end

      S_EX: begin
        alu_src_a    = SRC_A_REG;
        alu_src_b    = is_r ? SRC_B_REG : SRC_B_IMM;
        alu_op       = dec_alu_op;
        aluout_write = 1'b1;
        if (dec_illegal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_BR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        alu_op    = dec_alu_op;
        if (dec_illegal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          pc_write  = 1'b1;
          pc_source = alu_bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
          state_d   = S_IF;
        end
      end

      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) begin
            pc_write  = 1'b1;
            pc_source = PC_SRC_PC4;
            state_d   = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_c) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_load ? WB_MDR : WB_ALUOUT;
        pc_write  = 1'b1;
        pc_source = PC_SRC_PC4;
        state_d   = S_IF;
      end

      S_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC4;
        pc_write  = 1'b1;
        pc_source = PC_SRC_ALUOUT;
        state_d   = S_IF;
      end

      S_JALR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
        reg_write = 1'b1;
        wb_sel    = WB_PC4;
        pc_write  = 1'b1;
        pc_source = PC_SRC_ALU;
        state_d   = S_IF;
      end

      S_HALT: is_halted = 1'b1;

      default: begin
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase

    // Wait counter restarts on every state entry and advances while a request is open
    if (state_d != state_q) wait_cnt_d = '0;
    else if (mem_req)       wait_cnt_d = wait_cnt_q + CNT_W'(1);

    // Reset drops any open request immediately
    if (!reset_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      iord         = 1'b0;
      ir_write     = 1'b0;
      aluout_write = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'd0;
      alu_op       = 4'd0;
      reg_write    = 1'b0;
      wb_sel       = 2'd0;
      pc_write     = 1'b0;
      pc_source    = 2'd0;
      is_halted    = 1'b0;
      illegal      = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit.
// Each directed instruction is expanded by an instruction-level model into a
// per-cycle list of expected control outputs plus the memory/compare inputs to
// apply; the list is then played against the DUT and every cycle is compared.
module tb_multicycle_control_unit;

  logic        clk, reset_n;
  logic [31:0] ir;
  logic        mem_ready, alu_bcond, rf_x17_eq_10;
  logic        mem_req, mem_we, iord, ir_write, aluout_write, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_op;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        pc_write;
  logic [1:0]  pc_source;
  logic        is_halted, illegal;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       aluout_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       is_halted;
    logic       illegal;
  } outs_t;

  typedef struct packed {
    outs_t       o;
    logic        rdy;
    logic        bc;
    logic        x17;
    logic [31:0] ir;
    logic [63:0] tag;
  } step_t;

  step_t       tr[$];
  outs_t       dut_vec;
  int          checks, errors;
  logic [31:0] m_ir;
  logic        m_bc, m_x17;

  assign dut_vec = {mem_req, mem_we, iord, ir_write, aluout_write, alu_src_a, alu_src_b,
                    alu_op, reg_write, wb_sel, pc_write, pc_source, is_halted, illegal};

  multicycle_control_unit #(.MEM_TIMEOUT(0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ir           (ir),
    .mem_ready    (mem_ready),
    .alu_bcond    (alu_bcond),
    .rf_x17_eq_10 (rf_x17_eq_10),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .iord         (iord),
    .ir_write     (ir_write),
    .aluout_write (aluout_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .pc_write     (pc_write),
    .pc_source    (pc_source),
    .is_halted    (is_halted),
    .illegal      (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  task automatic push(input outs_t o, input logic rdy, input logic [63:0] tag);
    step_t s;
    s.o = o; s.rdy = rdy; s.bc = m_bc; s.x17 = m_x17; s.ir = m_ir; s.tag = tag;
    tr.push_back(s);
  endtask

  // {ok, alu_op} for register/immediate arithmetic
  function automatic logic [4:0] alu_table(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0:    return sub ? 5'h11 : 5'h10;
      3'd4:    return 5'h18;
      3'd6:    return 5'h15;
      3'd7:    return 5'h14;
      default: return 5'h00;
    endcase
  endfunction

  // {ok, alu_op} for conditional branches
  function automatic logic [4:0] br_table(input logic [2:0] f3);
    case (f3)
      3'd0:    return 5'h10;
      3'd1:    return 5'h1A;
      3'd6:    return 5'h18;
      3'd7:    return 5'h1B;
      default: return 5'h00;
    endcase
  endfunction

  task automatic halt_steps(input logic ill, input int n);
    outs_t o;
    for (int i = 0; i < n; i++) begin
      o = '0; o.is_halted = 1'b1; o.illegal = ill;
      push(o, (i % 2) == 1, "HALT");
    end
  endtask

  // Expected cycle sequence of one instruction, from fetch to return to fetch (or halt)
  task automatic model_instr(input logic [31:0] insn, input int if_lat, input int mem_lat,
                             input logic bc, input logic x17);
    outs_t      o;
    logic [6:0] opc;
    logic [4:0] t;
    m_ir = insn; m_bc = bc; m_x17 = x17;
    opc = insn[6:0];
    for (int i = 0; i < if_lat; i++) begin
      o = '0; o.mem_req = 1'b1; push(o, 1'b0, "IF");
    end
    o = '0; o.mem_req = 1'b1; o.ir_write = 1'b1; push(o, 1'b1, "IF");
    o = '0; o.alu_src_b = 2'd2; o.aluout_write = 1'b1;
    if (opc == 7'h73) begin
      if (x17) begin
        push(o, 1'b0, "ID");
        halt_steps(1'b0, 3);
      end else begin
        o.pc_write = 1'b1; push(o, 1'b0, "ID");
      end
    end else if (opc == 7'h33 || opc == 7'h13) begin
      push(o, 1'b0, "ID");
      t = alu_table(insn[14:12], opc == 7'h33 && insn[30]);
      o = '0; o.alu_src_a = 1'b1; o.alu_src_b = (opc == 7'h33) ? 2'd0 : 2'd2;
      o.alu_op = t[3:0]; o.aluout_write = 1'b1;
      push(o, 1'b0, "EX");
      if (!t[4]) halt_steps(1'b1, 3);
      else begin
        o = '0; o.reg_write = 1'b1; o.pc_write = 1'b1; push(o, 1'b0, "WB");
      end
    end else if (opc == 7'h03 || opc == 7'h23) begin
      push(o, 1'b0, "ID");
      o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.aluout_write = 1'b1;
      push(o, 1'b0, "EX");
      o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (opc == 7'h23);
      for (int i = 0; i < mem_lat; i++) push(o, 1'b0, "MEM");
      if (opc == 7'h23) begin
        o.pc_write = 1'b1; push(o, 1'b1, "MEM");
      end else begin
        push(o, 1'b1, "MEM");
        o = '0; o.reg_write = 1'b1; o.wb_sel = 2'd1; o.pc_write = 1'b1; push(o, 1'b0, "WB");
      end
    end else if (opc == 7'h63) begin
      push(o, 1'b0, "ID");
      t = br_table(insn[14:12]);
      o = '0; o.alu_src_a = 1'b1; o.alu_op = t[3:0];
      if (t[4]) begin
        o.pc_write = 1'b1; o.pc_source = bc ? 2'd1 : 2'd0;
      end
      push(o, 1'b0, "BR");
      if (!t[4]) halt_steps(1'b1, 3);
    end else if (opc == 7'h6F) begin
      push(o, 1'b0, "ID");
      o = '0; o.reg_write = 1'b1; o.wb_sel = 2'd2; o.pc_write = 1'b1; o.pc_source = 2'd1;
      push(o, 1'b0, "JAL");
    end else if (opc == 7'h67) begin
      push(o, 1'b0, "ID");
      o = '0; o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.reg_write = 1'b1; o.wb_sel = 2'd2;
      o.pc_write = 1'b1; o.pc_source = 2'd2;
      push(o, 1'b0, "JALR");
    end else begin
      push(o, 1'b0, "ID");
      halt_steps(1'b1, 3);
    end
  endtask

  // Play the expected list: drive after the falling edge, compare mid-low-phase
  task automatic run_trace();
    step_t s;
    while (tr.size() > 0) begin
      s = tr.pop_front();
      @(negedge clk);
      ir = s.ir; mem_ready = s.rdy; alu_bcond = s.bc; rf_x17_eq_10 = s.x17;
      #3;
      check_val($sformatf("%s cycle ir=%h", s.tag, s.ir), 32'(dut_vec), 32'(s.o));
    end
  endtask

  task automatic do_reset();
    outs_t f;
    f = '0; f.mem_req = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1 check_val("outputs during reset", 32'(dut_vec), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #2 check_val("fetch after reset", 32'(dut_vec), 32'(f));
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; ir = 32'd0; mem_ready = 1'b0; alu_bcond = 1'b0; rf_x17_eq_10 = 1'b0;
    m_ir = 32'd0; m_bc = 1'b0; m_x17 = 1'b0;
    #2 check_val("outputs at reset", 32'(dut_vec), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    model_instr(32'h002081B3, 2, 0, 1'b0, 1'b0);
    check_val("add trace length", 32'(tr.size()), 32'd6);
    check_val("add EX alu_op", 32'(tr[4].o.alu_op), 32'h0);
    check_val("add EX src a/b", 32'({tr[4].o.alu_src_a, tr[4].o.alu_src_b}), 32'h4);
    check_val("add WB regw/pcsrc", 32'({tr[5].o.reg_write, tr[5].o.pc_source}), 32'h4);
    run_trace();

    model_instr(32'h402081B3, 0, 0, 1'b0, 1'b0);
    check_val("sub EX alu_op", 32'(tr[2].o.alu_op), 32'h1);
    run_trace();

    model_instr(32'h0020F1B3, 1, 0, 1'b0, 1'b0);
    check_val("and EX alu_op", 32'(tr[3].o.alu_op), 32'h4);
    run_trace();

    model_instr(32'h00208463, 0, 0, 1'b1, 1'b0);
    check_val("beq taken pcw/pcsrc", 32'({tr[2].o.pc_write, tr[2].o.pc_source}), 32'h5);
    run_trace();

    model_instr(32'h00208463, 0, 0, 1'b0, 1'b0);
    check_val("beq not taken pcw/pcsrc", 32'({tr[2].o.pc_write, tr[2].o.pc_source}), 32'h4);
    run_trace();

    model_instr(32'h0040A183, 0, 3, 1'b0, 1'b0);
    check_val("lw trace length", 32'(tr.size()), 32'd8);
    check_val("lw WB wbsel/regw", 32'({tr[7].o.wb_sel, tr[7].o.reg_write}), 32'h3);
    run_trace();

    model_instr(32'h00000073, 0, 0, 1'b0, 1'b0);
    check_val("ecall continue pcw", 32'({tr[1].o.pc_write, tr[1].o.pc_source}), 32'h4);
    run_trace();

    model_instr(32'h008000EF, 1, 0, 1'b0, 1'b0);
    run_trace();
    model_instr(32'h000080E7, 0, 0, 1'b0, 1'b0);
    run_trace();

    model_instr(32'h00000073, 0, 0, 1'b0, 1'b1);
    check_val("ecall halt flag", 32'({tr[4].o.is_halted, tr[4].o.illegal}), 32'h2);
    run_trace();
    do_reset();

    // Store abandoned by reset while waiting on memory
    model_instr(32'h0020A223, 0, 2, 1'b0, 1'b0);
    void'(tr.pop_back());
    check_val("sw partial length", 32'(tr.size()), 32'd5);
    run_trace();
    @(negedge clk);
    #2 check_val("sw MEM req/we/iord", 32'({mem_req, mem_we, iord}), 32'h7);
    do_reset();

    model_instr(32'h002081B3, 1, 0, 1'b0, 1'b0);
    run_trace();

    model_instr(32'h00109093, 0, 0, 1'b0, 1'b0);
    check_val("slli illegal halt", 32'({tr[3].o.is_halted, tr[3].o.illegal}), 32'h3);
    run_trace();

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
